if_fetch_stage: RTL

- Instruction-fetch stage for the 16-bit pipelined CPU (no-cache build): owns the PC, drives the instruction-memory read handshake and holds the IF/ID pipeline register.
- Consumes the load-use hold signals from the hazard detector and branch/jump redirects from later stages.
- Feeds the decode stage, whose RS/RT fields go back to the hazard detector.

---
 rtl/if_fetch_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner, I-mem read handshake and IF/ID register for the 16-bit CPU (rev 1.0).
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt / perf_bubble_cnt counters.
`default_nettype none

module if_fetch_stage #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pc_hold,
  input  logic                 ifid_hold,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_mem_ready,
  output logic [WORD_SIZE-1:0] ifid_instr,
  output logic [WORD_SIZE-1:0] ifid_pc,
  output logic [WORD_SIZE-1:0] ifid_pc_next,
  output logic                 ifid_valid,
  output logic [WORD_SIZE-1:0] fetch_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_BUF  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam logic [WORD_SIZE-1:0] PC_INC = 1;

  state_t               state, nx_state;
  logic [WORD_SIZE-1:0] pc, nx_pc;
  logic [WORD_SIZE-1:0] req_addr, nx_req;
  logic [WORD_SIZE-1:0] buf_instr, nx_buf_instr;
  logic [WORD_SIZE-1:0] buf_pc, nx_buf_pc;
  logic [WORD_SIZE-1:0] nx_instr, nx_ipc, nx_ipc_next;
  logic                 nx_valid;
  logic                 ifid_we;
  logic                 hold;

  // Stalls are normally paired; OR-ing keeps the stage safe if they are not.
  assign hold      = pc_hold | ifid_hold;
  assign i_readM   = (state != S_BUF);
  assign i_address = req_addr;
  assign fetch_pc  = pc;

  always_comb begin
    nx_state     = state;
    nx_pc        = pc;
    nx_req       = req_addr;
    nx_buf_instr = buf_instr;
    nx_buf_pc    = buf_pc;
    nx_instr     = ifid_instr;
    nx_ipc       = ifid_pc;
    nx_ipc_next  = ifid_pc_next;
    nx_valid     = ifid_valid;
    ifid_we      = 1'b0;

    if (redirect) begin
      ifid_we  = 1'b1;
      nx_valid = 1'b0;
      nx_instr = NOP_INSTR;
      nx_pc    = redirect_pc;
      case (state)
        // Memory cannot cancel an unanswered request, so wait it out in S_DROP.
        S_REQ:   if (i_mem_ready) nx_req = redirect_pc;
                 else             nx_state = S_DROP;
        S_DROP:  ;
        default: begin
          nx_state = S_REQ;
          nx_req   = redirect_pc;
        end
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (i_mem_ready && !hold) begin
            ifid_we     = 1'b1;
            nx_instr    = i_data;
            nx_ipc      = pc;
            nx_ipc_next = pc + PC_INC;
            nx_valid    = 1'b1;
            nx_pc       = pc + PC_INC;
            nx_req      = pc + PC_INC;
          end else if (i_mem_ready) begin
            nx_buf_instr = i_data;
            nx_buf_pc    = pc;
            nx_state     = S_BUF;
          end else if (!hold) begin
            ifid_we  = 1'b1;
            nx_valid = 1'b0;
            nx_instr = NOP_INSTR;
          end
        end
        S_BUF: begin
          if (!hold) begin
            ifid_we     = 1'b1;
            nx_instr    = buf_instr;
            nx_ipc      = buf_pc;
            nx_ipc_next = buf_pc + PC_INC;
            nx_valid    = 1'b1;
            nx_pc       = buf_pc + PC_INC;
            nx_req      = buf_pc + PC_INC;
            nx_state    = S_REQ;
          end
        end
        S_DROP: begin
          if (i_mem_ready) begin
            nx_req   = pc;
            nx_state = S_REQ;
          end
        end
        default: nx_state = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      buf_instr    <= '0;
      buf_pc       <= '0;
      ifid_instr   <= NOP_INSTR;
      ifid_pc      <= '0;
      ifid_pc_next <= '0;
      ifid_valid   <= 1'b0;
    end else begin
      state     <= nx_state;
      pc        <= nx_pc;
      req_addr  <= nx_req;
      buf_instr <= nx_buf_instr;
      buf_pc    <= nx_buf_pc;
      if (ifid_we) begin
        ifid_instr   <= nx_instr;
        ifid_pc      <= nx_ipc;
        ifid_pc_next <= nx_ipc_next;
        ifid_valid   <= nx_valid;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else if (ifid_we) begin
      if (nx_valid) perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      else          perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
